// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM state and BCD digit types for the double-dabble converter
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef logic [3:0] digit_t;
  function automatic int min_digits(input int bin_w);
    return (bin_w * 30103) / 100000 + 1;
  endfunction
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: per-digit shift-add-3 correction applied before each left shift
module bcd_add3 import bcd_pkg::*; (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = digit_t'(d >= 4'd5 ? d + 4'd3 : d);
endmodule

// File: rtl/bcd_dabble_seq.sv
// bcd_dabble_seq: sequential binary-to-BCD converter, one bit per clock with valid/ready handshakes
module bcd_dabble_seq import bcd_pkg::*; #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  busy
);
  localparam int CW = $clog2(BIN_W + 1);
  localparam int DW = 4 * DIGITS;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [BIN_W-1:0] sh;
  logic [DW-1:0] dig, adj;
  logic [DW+BIN_W-1:0] nxt;
  logic load, last;
  if (DIGITS < min_digits(BIN_W)) begin : g_chk
    $fatal(1, "bcd_dabble_seq: DIGITS too small for BIN_W");
  end
  for (genvar i = 0; i < DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (.d(dig[4*i +: 4]), .q(adj[4*i +: 4]));
  end
  assign nxt       = {adj, sh} << 1;
  assign last      = cnt == CW'(1);
  assign in_ready  = rst_n & (state == IDLE | (state == DONE & out_ready));
  assign load      = in_valid & in_ready;
  assign out_valid = state == DONE;
  assign busy      = state == SHIFT;
  always_comb begin
    state_n = state;
    state_n = load ? SHIFT :
              state == SHIFT ? (last ? DONE : SHIFT) :
              (state == DONE & out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      sh      <= '0;
      dig     <= '0;
      out_bcd <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        sh  <= in_bin;
        dig <= '0;
        cnt <= CW'(BIN_W);
      end else if (state == SHIFT) begin
        {dig, sh} <= nxt;
        cnt       <= cnt - 1'b1;
        if (last) out_bcd <= nxt[DW+BIN_W-1 -: DW];
      end
    end
  end
endmodule
